// File: rtl/spi_cmd_pkg.sv
// Shared opcode constants and FSM state encoding for the SPI command register file.
package spi_cmd_pkg;

  localparam logic [7:0] OP_START   = 8'h06;
  localparam logic [7:0] OP_STOP    = 8'h04;
  localparam logic [7:0] OP_WR_BASE = 8'h90;
  localparam logic [7:0] OP_RD_BASE = 8'hA0;
  localparam logic [7:0] OP_FB      = 8'hAB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_FEEDBACK,
    ST_DISCARD
  } state_e;

  // True when the opcode's upper nibble selects the given register-access family.
  function automatic logic opFamily(input logic [7:0] op, input logic [7:0] base);
    return op[7:4] == base[7:4];
  endfunction

endpackage

// File: rtl/spi_cmd_regfile.sv
// Byte-level SPI command decoder with a small writable register file, register
// read-back and a frozen feedback snapshot. The parent connects an SPI bit engine
// to rx_byte/rx_valid/tx_byte.
module spi_cmd_regfile
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int REG_BYTES   = 2,
  parameter int FB_BYTES    = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cs_n,
  input  logic [7:0]                      rx_byte,
  input  logic                            rx_valid,
  output logic [7:0]                      tx_byte,
  input  logic [FB_BYTES*8-1:0]           feedback,
  output logic [NUM_REGS*REG_BYTES*8-1:0] reg_data,
  output logic [NUM_REGS-1:0]             reg_update,
  output logic                            machine_start,
  output logic                            machine_stop,
  output logic                            cmd_error
);

  localparam int RW = REG_BYTES * 8;
  localparam int FW = FB_BYTES * 8;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int CW = 4;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [TW-1:0]              idle_q, idle_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [RW-1:0]              shadow_q, shadow_d;
  logic [NUM_REGS-1:0][RW-1:0] regs_q, regs_d;
  logic [FW-1:0]              snap_q, snap_d;
  logic [7:0]                 tx_q, tx_d;
  logic [NUM_REGS-1:0]        upd_q, upd_d;
  logic                       start_q, start_d;
  logic                       stop_q, stop_d;
  logic                       err_q, err_d;

  logic          rxStrobe;
  logic          timeoutHit;
  logic          abortReq;
  logic          lastReg;
  logic          lastFb;
  logic          opRegOk;
  logic [RW-1:0] wrMerge;

  // Bytes arriving while the chip is deselected are not part of any frame.
  assign rxStrobe   = rx_valid & ~cs_n;
  // The counter holds the number of strobe-free cycles already spent in a busy state,
  // so reaching TIMEOUT_CYC-1 with no strobe this cycle completes the idle window.
  assign timeoutHit = (state_q != ST_IDLE) & ~rxStrobe & (idle_q == TW'(TIMEOUT_CYC - 1));
  // Deselect during a payload phase or an expired idle window forces a return to IDLE;
  // DISCARD leaves quietly on deselect, so only its timeout counts as an abort.
  assign abortReq   = timeoutHit |
                      (cs_n & ((state_q == ST_WRITE) | (state_q == ST_READ) |
                               (state_q == ST_FEEDBACK)));
  assign lastReg    = (cnt_q == CW'(REG_BYTES - 1));
  assign lastFb     = (cnt_q == CW'(FB_BYTES - 1));
  assign opRegOk    = (int'(rx_byte[3:0]) < NUM_REGS);
  // Payload bytes land little-endian; the shadow is cleared on opcode so OR-merge is safe.
  assign wrMerge    = shadow_q | (RW'(rx_byte) << (8 * cnt_q));

  // Next-state, datapath and pulse generation; everything defaults to hold/idle first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = ((state_q == ST_IDLE) || rxStrobe) ? '0 : idle_q + TW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    snap_d   = cs_n ? feedback : snap_q;
    tx_d     = 8'hFF;
    upd_d    = '0;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        shadow_d = '0;
        if (rxStrobe) begin
          // The feedback opcode is matched before the read family, so it shadows read of reg 11.
          if (rx_byte == OP_START) begin
            start_d = 1'b1;
          end else if (rx_byte == OP_STOP) begin
            stop_d = 1'b1;
          end else if (rx_byte == OP_FB) begin
            state_d = ST_FEEDBACK;
            tx_d    = snap_q[7:0];
          end else if (opFamily(rx_byte, OP_WR_BASE) && opRegOk) begin
            state_d = ST_WRITE;
            idx_d   = rx_byte[IW-1:0];
          end else if (opFamily(rx_byte, OP_RD_BASE) && opRegOk) begin
            state_d = ST_READ;
            idx_d   = rx_byte[IW-1:0];
            tx_d    = regs_q[rx_byte[IW-1:0]][7:0];
          end else begin
            state_d = ST_DISCARD;
            err_d   = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (rxStrobe) begin
          if (lastReg) begin
            regs_d[idx_q] = wrMerge;
            upd_d[idx_q]  = 1'b1;
            shadow_d      = '0;
            cnt_d         = '0;
            state_d       = ST_IDLE;
          end else begin
            shadow_d = wrMerge;
            cnt_d    = cnt_q + CW'(1);
          end
        end
      end

      ST_READ: begin
        if (rxStrobe) begin
          if (lastReg) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tx_d  = 8'(regs_q[idx_q] >> (8 * (cnt_q + CW'(1))));
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          tx_d = tx_q;
        end
      end

      ST_FEEDBACK: begin
        if (rxStrobe) begin
          if (lastFb) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tx_d  = 8'(snap_q >> (8 * (cnt_q + CW'(1))));
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          tx_d = tx_q;
        end
      end

      ST_DISCARD: begin
        if (cs_n) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abortReq) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      idle_d   = '0;
      shadow_d = '0;
      regs_d   = regs_q;
      upd_d    = '0;
      tx_d     = 8'hFF;
      err_d    = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idle_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      regs_q   <= '0;
      snap_q   <= '0;
      tx_q     <= 8'hFF;
      upd_q    <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
      snap_q   <= snap_d;
      tx_q     <= tx_d;
      upd_q    <= upd_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
    end
  end

  assign tx_byte       = tx_q;
  assign reg_data      = regs_q;
  assign reg_update    = upd_q;
  assign machine_start = start_q;
  assign machine_stop  = stop_q;
  assign cmd_error     = err_q;

endmodule

// File: doc/spi_cmd_regfile.md
SPI_CMD_REGFILE -- requirements
Module: spi_cmd_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of writable registers (1..16).
REQ-002 SHALL have parameter REG_BYTES, default 2, bytes per register (1..4).
REQ-003 SHALL have parameter FB_BYTES, default 4, feedback word bytes (1..8).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, idle-byte abort limit in clk cycles (>=16).
REQ-005 SHALL have port clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port cs_n  input  1  SPI chip select, already synchronised to clk.
REQ-008 SHALL have port rx_byte  input  8  received byte from bit engine.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_byte.
REQ-010 SHALL have port tx_byte  output  8  next byte for bit engine to shift out.
REQ-011 SHALL have port feedback  input  FB_BYTES*8  live status word.
REQ-012 SHALL have port reg_data  output  NUM_REGS*REG_BYTES*8  register contents, register i at bits [i*REG_BYTES*8 +: REG_BYTES*8].
REQ-013 SHALL have port reg_update  output  NUM_REGS  one-hot one-cycle pulse on register commit.
REQ-014 SHALL have ports machine_start, machine_stop  output  1  one-cycle command pulses.
REQ-015 SHALL have port cmd_error  output  1  one-cycle pulse on any abort or illegal opcode.

Function
REQ-016 SHALL decode opcodes in IDLE: 0x06 start, 0x04 stop, 0x90|i write reg i, 0xA0|i read reg i, 0xAB feedback read; others illegal.
REQ-017 SHALL pulse machine_start/machine_stop one cycle after the opcode rx_valid, remaining in IDLE.
REQ-018 SHALL treat i>=NUM_REGS and unlisted opcodes as illegal: pulse cmd_error, enter DISCARD until cs_n high.
REQ-019 SHALL implement states IDLE, WRITE, READ, FEEDBACK, DISCARD; byte counter resets on every IDLE entry.
REQ-020 SHALL in WRITE stage REG_BYTES payload bytes little-endian into a shadow register; target register unchanged until all bytes received.
REQ-021 SHALL on last payload byte commit shadow to register i atomically and pulse reg_update[i] in the same cycle reg_data changes, one cycle after the strobe; return to IDLE.
REQ-022 SHALL in READ drive tx_byte with register i byte 0 one cycle after the opcode strobe and byte k+1 one cycle after the k-th payload strobe; return to IDLE after REG_BYTES strobes.
REQ-023 SHALL snapshot feedback every cycle while cs_n=1 and freeze it while cs_n=0; FEEDBACK returns snapshot bytes little-endian as in REQ-022, FB_BYTES strobes.
REQ-024 SHALL drive tx_byte=0xFF whenever not in READ/FEEDBACK payload.
REQ-025 SHALL abort to IDLE with cmd_error pulse, shadow discarded, if cs_n rises in WRITE/READ/FEEDBACK before completion.
REQ-026 SHALL abort likewise when TIMEOUT_CYC consecutive cycles pass in a non-IDLE state without rx_valid; counter clears on each strobe.
REQ-027 SHALL give abort priority over a same-cycle rx_valid; that byte is dropped.
REQ-028 SHALL ignore rx_valid while cs_n=1.
REQ-029 SHALL leave DISCARD to IDLE on cs_n=1 without further cmd_error.

Reset
REQ-030 SHALL on rst_n low set state IDLE, all registers and shadow 0, snapshot 0, tx_byte 0xFF, all pulses 0, counters 0.
REQ-031 SHALL accept reset mid-transaction with no commit and no cmd_error.

Structure
REQ-032 SHALL place opcode constants (OP_START, OP_STOP, OP_WR_BASE, OP_RD_BASE, OP_FB) and state encoding in shared package spi_cmd_pkg.
REQ-033 SHALL be a byte-level core with no sub-module; parent instantiates spi_slave_driver (mode 2'b11) and connects rx_byte/rx_valid/tx_byte.

Verification
REQ-034 SHALL cover: 0x92,0x34,0x12 -> reg 2=0x1234, reg_update=4'b0100 once, other regs 0.
REQ-035 SHALL cover: 0x91,0x55 then cs_n high -> cmd_error pulse, reg 1 stays 0, no reg_update.
REQ-036 SHALL cover: feedback=0xDEADBEEF, cs_n low, 0xAB then 4 dummy bytes -> tx_byte 0xEF,0xBE,0xAD,0xDE, then 0xFF; feedback change mid-frame not seen.
REQ-037 SHALL cover: 0x90,0xAA then TIMEOUT_CYC idle cycles -> cmd_error at cycle TIMEOUT_CYC, IDLE, reg 0 unchanged.
REQ-038 SHALL cover: 0xA7 with NUM_REGS=4 -> cmd_error, following 0x06 ignored until cs_n high; 0x06 in new frame -> machine_start single pulse.
